vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA timing generator. Consumes hsync/vsync/active_video as driven onto the video interface and recovers pixel coordinates. Measures line length, frame height and hsync width, and declares lock after consecutive conforming frames. Sits on the video output path as an in-system monitor and is reused as a checker in generator benches.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_sync_edge.sv | 37 +++
 rtl/vga_sync_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: timing constants and lock-state encoding shared by the VGA timing
// generator and the receive-side sync decoder.
//   640x480@60 line/frame geometry (active, front porch, sync, back porch)
//   lock_state_e : lock FSM encoding used by vga_sync_decoder
package vga_pkg;

  localparam int H_ACTIVE_PX = 640;
  localparam int H_FP_PX     = 16;
  localparam int H_SYNC_PX   = 96;
  localparam int H_BP_PX     = 48;
  localparam int H_TOTAL_PX  = H_ACTIVE_PX + H_FP_PX + H_SYNC_PX + H_BP_PX;

  localparam int V_ACTIVE_LN = 480;
  localparam int V_FP_LN     = 10;
  localparam int V_SYNC_LN   = 2;
  localparam int V_BP_LN     = 33;
  localparam int V_TOTAL_LN  = V_ACTIVE_LN + V_FP_LN + V_SYNC_LN + V_BP_LN;

  localparam int CNT_W_DEF       = 12;
  localparam int LOCK_FRAMES_DEF = 2;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: pix_ce-gated sync sampler with polarity normalisation.
//   clk_i, reset_i : clock and synchronous active-high reset
//   pix_ce_i       : pixel-rate enable; only these cycles sample sync_i
//   sync_i         : raw sync from the video interface
//   level_o        : sync asserted in the current sample (pix_ce cycles only)
//   lead_o/trail_o : asserted/deasserted transition versus the previous sample
// All strobes are single-cycle and only ever high on a pix_ce cycle.
module vga_sync_edge #(
  parameter logic SYNC_POL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pix_ce_i,
  input  logic sync_i,
  output logic level_o,
  output logic lead_o,
  output logic trail_o
);

  logic asserted;
  logic prev_q;

  assign asserted = (sync_i == SYNC_POL);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q <= 1'b0;
    end else if (pix_ce_i) begin
      prev_q <= asserted;
    end
  end

  assign level_o = pix_ce_i & asserted;
  assign lead_o  = pix_ce_i & asserted & ~prev_q;
  assign trail_o = pix_ce_i & ~asserted & prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from hsync/vsync/active_video,
// measures line length, frame height and hsync width, and tracks lock.
//   clk, reset            : clock and synchronous active-high reset
//   pix_ce                : pixel-rate enable
//   hsync_in, vsync_in    : interface syncs (asserted level = SYNC_POL)
//   de_in                 : interface active_video
//   x_out, y_out, de_out  : recovered coordinates and window (0 outside window)
//   frame_start           : pulse on vsync leading edge
//   h_total_meas, v_total_meas, hsync_w_meas : last measurements
//   locked                : lock status
//   err_hlen, err_vlen    : pulse on line/frame length mismatch
//   err_de                : pulse when de_in disagrees with the recovered window
// Optional: define VGA_DE_CHECK_EN to enable the de_in cross-check; otherwise
// de_in is ignored and err_de is constant 0.
//
// Lock FSM:
//   state   | meaning
//   SEARCH  | no reference; waiting for a vsync leading edge
//   ACQUIRE | counting consecutive error-free frames
//   LOCKED  | LOCK_FRAMES good frames seen; window outputs enabled
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int   H_TOTAL     = H_TOTAL_PX,
  parameter int   V_TOTAL     = V_TOTAL_LN,
  parameter int   H_SYNC_W    = H_SYNC_PX,
  parameter int   H_START     = H_SYNC_PX + H_BP_PX,
  parameter int   V_START     = V_SYNC_LN + V_BP_LN,
  parameter int   H_ACTIVE    = H_ACTIVE_PX,
  parameter int   V_ACTIVE    = V_ACTIVE_LN,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int   CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_ce,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  output logic [9:0]       x_out,
  output logic [9:0]       y_out,
  output logic             de_out,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_total_meas,
  output logic [CNT_W-1:0] v_total_meas,
  output logic [CNT_W-1:0] hsync_w_meas,
  output logic             locked,
  output logic             err_hlen,
  output logic             err_vlen,
  output logic             err_de
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] H_TOTAL_C  = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_TOTAL_C  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_START_C  = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] V_START_C  = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] H_ACTIVE_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic hs_level, hs_lead, hs_trail;
  logic vs_level, vs_lead, vs_trail;

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
    .clk_i(clk), .reset_i(reset), .pix_ce_i(pix_ce), .sync_i(hsync_in),
    .level_o(hs_level), .lead_o(hs_lead), .trail_o(hs_trail)
  );

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
    .clk_i(clk), .reset_i(reset), .pix_ce_i(pix_ce), .sync_i(vsync_in),
    .level_o(vs_level), .lead_o(vs_lead), .trail_o(vs_trail)
  );

  // Only the vsync leading edge matters; the nominal hsync width is reported
  // through the measurement, not judged.
  logic             unused_vs;
  logic [CNT_W-1:0] unused_hsw_nom;
  assign unused_vs      = vs_level ^ vs_trail;
  assign unused_hsw_nom = CNT_W'(H_SYNC_W);

  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CNT_W-1:0] hmeas_q, hmeas_d, vmeas_q, vmeas_d;
  logic [CNT_W-1:0] hsw_q, hsw_d, hswm_q, hswm_d;
  lock_state_e      state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic             ferr_q, ferr_d;
  logic [CNT_W-1:0] hx, vy;
  logic             win, hlen_err, vlen_err, de_err, any_err, sat_hit;

  // Line close is applied before frame close so a coincident vsync edge sees
  // the line count including the line just finished.
  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    hmeas_d = hmeas_q;
    vmeas_d = vmeas_q;
    hsw_d   = hsw_q;
    hswm_d  = hswm_q;
    if (pix_ce) hcnt_d = sat_inc(hcnt_q);
    if (hs_lead) begin
      hmeas_d = sat_inc(hcnt_q);
      hcnt_d  = '0;
      vcnt_d  = sat_inc(vcnt_q);
    end
    if (vs_lead) begin
      vmeas_d = vcnt_d;
      vcnt_d  = '0;
    end
    if (hs_lead)       hsw_d = CNT_W'(1);
    else if (hs_level) hsw_d = sat_inc(hsw_q);
    if (hs_trail)      hswm_d = hsw_q;
  end

  // Unsigned wrap makes positions before the start offset compare as huge.
  assign hx  = hcnt_d - H_START_C;
  assign vy  = vcnt_d - V_START_C;
  assign win = (hx < H_ACTIVE_C) && (vy < V_ACTIVE_C);

  assign hlen_err = hs_lead && (hmeas_d != H_TOTAL_C) && (state_q != SEARCH);
  assign vlen_err = vs_lead && (vmeas_d != V_TOTAL_C) && (state_q != SEARCH);

`ifdef VGA_DE_CHECK_EN
  assign de_err = pix_ce && (state_q == LOCKED) && (de_in != win);
`else
  logic unused_de;
  assign unused_de = de_in;
  assign de_err    = 1'b0;
`endif

  assign any_err  = hlen_err | vlen_err | de_err;
  assign sat_hit  = (hcnt_q == CNT_MAX) || (vcnt_q == CNT_MAX);
  assign good_inc = good_q + GOOD_W'(1);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      SEARCH: begin
        if (vs_lead) begin
          state_d = ACQUIRE;
          good_d  = '0;
          ferr_d  = 1'b0;
        end
      end
      ACQUIRE: begin
        if (vs_lead) begin
          ferr_d = 1'b0;
          if (ferr_q || any_err) begin
            good_d = '0;
          end else begin
            good_d = good_inc;
            if (good_inc == GOOD_W'(LOCK_FRAMES)) state_d = LOCKED;
          end
        end else if (any_err) begin
          ferr_d = 1'b1;
        end
      end
      LOCKED: begin
        if (any_err) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
    if (sat_hit) state_d = SEARCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      hmeas_q      <= '0;
      vmeas_q      <= '0;
      hsw_q        <= '0;
      hswm_q       <= '0;
      state_q      <= SEARCH;
      good_q       <= '0;
      ferr_q       <= 1'b0;
      x_out        <= '0;
      y_out        <= '0;
      de_out       <= 1'b0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      err_hlen     <= 1'b0;
      err_vlen     <= 1'b0;
      err_de       <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      hmeas_q      <= hmeas_d;
      vmeas_q      <= vmeas_d;
      hsw_q        <= hsw_d;
      hswm_q       <= hswm_d;
      state_q      <= state_d;
      good_q       <= good_d;
      ferr_q       <= ferr_d;
      de_out       <= (state_d == LOCKED) && win;
      x_out        <= ((state_d == LOCKED) && win) ? hx[9:0] : 10'd0;
      y_out        <= ((state_d == LOCKED) && win) ? vy[9:0] : 10'd0;
      frame_start  <= vs_lead;
      locked       <= (state_d == LOCKED);
      err_hlen     <= hlen_err;
      err_vlen     <= vlen_err;
      err_de       <= de_err;
    end
  end

  assign h_total_meas = hmeas_q;
  assign v_total_meas = vmeas_q;
  assign hsync_w_meas = hswm_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a miniature raster so the whole run stays
// short: 24 px/line (4 sync, 3 BP, 14 active, 3 FP), 10 lines/frame
// (2 sync, 2 BP, 5 active, 1 FP), pix_ce every 4 clocks, active-low syncs.
module tb_vga_sync_decoder;

  localparam int HT = 24, VT = 10, HSW = 4, HS = 7, VS = 4, HA = 14, VA = 5;
  localparam int CW = 12;

  logic          clk, reset, pix_ce, hsync_in, vsync_in, de_in;
  logic [9:0]    x_out, y_out;
  logic          de_out, frame_start, locked, err_hlen, err_vlen, err_de;
  logic [CW-1:0] h_total_meas, v_total_meas, hsync_w_meas;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_W(HSW), .H_START(HS), .V_START(VS),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_POL(1'b0), .LOCK_FRAMES(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .de_in(de_in), .x_out(x_out), .y_out(y_out),
    .de_out(de_out), .frame_start(frame_start), .h_total_meas(h_total_meas),
    .v_total_meas(v_total_meas), .hsync_w_meas(hsync_w_meas), .locked(locked),
    .err_hlen(err_hlen), .err_vlen(err_vlen), .err_de(err_de)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse monitor: counts events and notes lock rise context.
  int            fs_cnt, hlen_cnt, vlen_cnt, de_cnt, err_lock, wide_cnt, lock_rise_fs;
  logic          lock_rise_sync, locked_prev, hlen_prev;
  logic [CW-1:0] hlen_val;

  initial begin
    fs_cnt = 0; hlen_cnt = 0; vlen_cnt = 0; de_cnt = 0; err_lock = 0;
    wide_cnt = 0; lock_rise_fs = 0; lock_rise_sync = 1'b0;
    locked_prev = 1'b0; hlen_prev = 1'b0; hlen_val = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        fs_cnt = 0; hlen_cnt = 0; vlen_cnt = 0; de_cnt = 0; err_lock = 0;
        wide_cnt = 0; lock_rise_fs = 0; lock_rise_sync = 1'b0;
      end else begin
        if (frame_start) fs_cnt++;
        if (err_hlen) begin
          hlen_cnt++;
          hlen_val = h_total_meas;
          if (hlen_prev) wide_cnt++;
        end
        if (err_vlen) vlen_cnt++;
        if (err_de) de_cnt++;
        if ((err_hlen || err_vlen || err_de) && locked) err_lock++;
        if (locked && !locked_prev) begin
          lock_rise_fs   = fs_cnt;
          lock_rise_sync = frame_start;
        end
      end
      locked_prev = locked;
      hlen_prev   = err_hlen;
    end
  end

  typedef struct {
    int         ln;
    int         p;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
  } probe_t;

  localparam int NPROBE = 8;
  probe_t probes [NPROBE];

  task automatic check_probes(input int ln, input int p);
    for (int i = 0; i < NPROBE; i++) begin
      if (probes[i].ln == ln && probes[i].p == p) begin
        chk($sformatf("probe%0d_de", i), 64'(de_out), 64'(probes[i].de));
        chk($sformatf("probe%0d_x", i),  64'(x_out),  64'(probes[i].x));
        chk($sformatf("probe%0d_y", i),  64'(y_out),  64'(probes[i].y));
      end
    end
  endtask

  task automatic pix(input bit hs, input bit vs, input bit de);
    hsync_in = ~hs;
    vsync_in = ~vs;
    de_in    = de;
    pix_ce   = 1'b1;
    @(posedge clk);
    #1;
    pix_ce = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int short_ln, input int drop_ln, input int drop_p,
                       input bit probe, input int stop_at);
    int idx;
    int len;
    bit de;
    idx = 0;
    for (int ln = 0; ln < VT; ln++) begin
      len = (ln == short_ln) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        if (idx == stop_at) return;
        de = (ln >= VS) && (ln < VS + VA) && (p >= HS) && (p < HS + HA);
        if (ln == drop_ln && p == drop_p) de = 1'b0;
        pix(p < HSW, ln < 2, de);
        if (probe) check_probes(ln, p);
        idx++;
      end
    end
  endtask

  task automatic frames_clean(input int n);
    for (int i = 0; i < n; i++) frame(-1, -1, -1, 1'b0, -1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({x_out, y_out, de_out, frame_start, h_total_meas, v_total_meas,
                hsync_w_meas, locked, err_hlen, err_vlen, err_de});
  endfunction

  initial begin
    probes[0] = '{ln: 4, p: 7,  de: 1'b1, x: 10'd0,  y: 10'd0};
    probes[1] = '{ln: 4, p: 6,  de: 1'b0, x: 10'd0,  y: 10'd0};
    probes[2] = '{ln: 4, p: 20, de: 1'b1, x: 10'd13, y: 10'd0};
    probes[3] = '{ln: 4, p: 21, de: 1'b0, x: 10'd0,  y: 10'd0};
    probes[4] = '{ln: 3, p: 10, de: 1'b0, x: 10'd0,  y: 10'd0};
    probes[5] = '{ln: 8, p: 20, de: 1'b1, x: 10'd13, y: 10'd4};
    probes[6] = '{ln: 9, p: 10, de: 1'b0, x: 10'd0,  y: 10'd0};
    probes[7] = '{ln: 6, p: 12, de: 1'b1, x: 10'd5,  y: 10'd2};

    reset = 1'b1; pix_ce = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;

    // Acquisition: lock on the third vsync edge, window probed in frame 3.
    frames_clean(2);
    chk("pre_lock", 64'(locked), 64'd0);
    frame(-1, -1, -1, 1'b1, -1);
    chk("lock_rise_fs", 64'(lock_rise_fs), 64'd3);
    chk("lock_with_fs", 64'(lock_rise_sync), 64'd1);
    chk("locked", 64'(locked), 64'd1);
    chk("h_meas", 64'(h_total_meas), 64'(HT));
    chk("v_meas", 64'(v_total_meas), 64'(VT));
    chk("hsw_meas", 64'(hsync_w_meas), 64'(HSW));
    chk("no_err_clean", 64'(hlen_cnt + vlen_cnt + de_cnt), 64'd0);

    // Short line while locked.
    frame(5, -1, -1, 1'b0, -1);
    chk("hlen_pulses", 64'(hlen_cnt), 64'd1);
    chk("hlen_val", 64'(hlen_val), 64'(HT - 1));
    chk("hlen_wide", 64'(wide_cnt), 64'd0);
    chk("drop_same_clk", 64'(err_lock), 64'd0);
    chk("lost_after_short", 64'(locked), 64'd0);
    frames_clean(2);
    chk("relock_early", 64'(locked), 64'd0);
    frame(-1, -1, -1, 1'b1, -1);
    chk("relock", 64'(locked), 64'd1);

    // One active pixel with de_in dropped.
    frame(-1, 6, 10, 1'b0, -1);
`ifdef VGA_DE_CHECK_EN
    chk("de_err_pulses", 64'(de_cnt), 64'd1);
    chk("de_err_lock", 64'(locked), 64'd0);
`else
    chk("de_err_pulses", 64'(de_cnt), 64'd0);
    chk("de_err_lock", 64'(locked), 64'd1);
`endif
    chk("de_drop_same_clk", 64'(err_lock), 64'd0);
    frames_clean(3);
    chk("locked_before_stop", 64'(locked), 64'd1);
    chk("vlen_none", 64'(vlen_cnt), 64'd0);

    // Syncs stop: hcnt must pin at 4095 and lock must drop.
    for (int i = 0; i < 5000; i++) pix(1'b0, 1'b0, 1'b0);
    chk("stop_unlock", 64'(locked), 64'd0);
    chk("stop_de", 64'(de_out), 64'd0);
    pix(1'b1, 1'b1, 1'b0);
    chk("sat_h_meas", 64'(h_total_meas), 64'd4095);
    chk("sat_no_hlen", 64'(hlen_cnt), 64'd1);
    pix(1'b0, 1'b0, 1'b0);
    frames_clean(3);
    chk("locked_after_stop", 64'(locked), 64'd1);

    // Reset mid-line inside the active window while locked.
    frame(-1, -1, -1, 1'b0, 4 * HT + 12);
    chk("pre_reset_de", 64'(de_out), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_outs", all_outs(), 64'd0);
    reset = 1'b0;
    frames_clean(2);
    chk("post_reset_early", 64'(locked), 64'd0);
    frame(-1, -1, -1, 1'b1, -1);
    chk("post_reset_lock", 64'(locked), 64'd1);
    chk("post_reset_fs", 64'(lock_rise_fs), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
